window_3x3_gen: RTL and testbench



---
 rtl/window_3x3_gen.sv | 171 +++++++++++++++++
 tb/tb_window_3x3_gen.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_3x3_gen.sv
`default_nettype none
// ============================================================================
// Module   : window_3x3_gen
// Purpose  : Line-buffered 3x3 window generator for a raster-order pixel
//            stream. Emits full-interior windows only (no border padding),
//            one clock after the pixel that completes each window.
// Options  : WINDOW_FRAME_CHK_EN adds a sticky frame_err output flagging
//            truncated frames and missing start-of-frame markers.
// Revision : 1.0 - initial release
// ============================================================================
module window_3x3_gen #(
  parameter int DATA_W     = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int ADDR_W     = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     pix_in,
  input  logic                  pix_valid,
  input  logic                  sof,
  output logic [3*DATA_W-1:0]   win_top,
  output logic [3*DATA_W-1:0]   win_mid,
  output logic [3*DATA_W-1:0]   win_bot,
  output logic                  win_valid,
  output logic [ADDR_W-1:0]     win_x,
  output logic [ADDR_W-1:0]     win_y
`ifdef WINDOW_FRAME_CHK_EN
  ,
  output logic                  frame_err
`endif
);

  // Line buffer address width: just enough to index IMG_WIDTH entries.
  localparam int LB_AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

  localparam logic [ADDR_W-1:0] C_LAST_COL = ADDR_W'(IMG_WIDTH - 1);
  localparam logic [ADDR_W-1:0] C_LAST_ROW = ADDR_W'(IMG_HEIGHT - 1);
  localparam logic [ADDR_W-1:0] C_ONE      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] C_TWO      = ADDR_W'(2);

  // Raster position of the next expected pixel.
  logic [ADDR_W-1:0] r_col;
  logic [ADDR_W-1:0] r_row;

  // lb0 holds the previous row, lb1 the row before that. Not reset: the
  // x>=2 / y>=2 gating guarantees stale contents never reach the outputs.
  logic [DATA_W-1:0] r_lb0 [0:IMG_WIDTH-1];
  logic [DATA_W-1:0] r_lb1 [0:IMG_WIDTH-1];

  // Per-row column shift registers; newest pixel lives in the MSB lane.
  logic [3*DATA_W-1:0] r_sh_top;
  logic [3*DATA_W-1:0] r_sh_mid;
  logic [3*DATA_W-1:0] r_sh_bot;

  logic                w_acc;
  logic [ADDR_W-1:0]   w_x;
  logic [ADDR_W-1:0]   w_y;
  logic [LB_AW-1:0]    w_addr;
  logic [DATA_W-1:0]   w_lb0_rd;
  logic [DATA_W-1:0]   w_lb1_rd;
  logic [3*DATA_W-1:0] w_top_nxt;
  logic [3*DATA_W-1:0] w_mid_nxt;
  logic [3*DATA_W-1:0] w_bot_nxt;
  logic                w_win;
  logic                w_last_col;
  logic                w_last_row;

  // Position of the accepted pixel (sof forces the origin), buffer reads
  // and the shifted window rows this pixel would produce.
  always_comb begin
    w_acc      = pix_valid;
    w_x        = sof ? '0 : r_col;
    w_y        = sof ? '0 : r_row;
    w_addr     = w_x[LB_AW-1:0];
    w_lb0_rd   = r_lb0[w_addr];
    w_lb1_rd   = r_lb1[w_addr];
    w_top_nxt  = {w_lb1_rd, r_sh_top[3*DATA_W-1:DATA_W]};
    w_mid_nxt  = {w_lb0_rd, r_sh_mid[3*DATA_W-1:DATA_W]};
    w_bot_nxt  = {pix_in,   r_sh_bot[3*DATA_W-1:DATA_W]};
    w_win      = (w_x >= C_TWO) && (w_y >= C_TWO);
    w_last_col = (w_x == C_LAST_COL);
    w_last_row = (w_y == C_LAST_ROW);
  end

  // Raster counters: column wraps at line end, row wraps at frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_acc) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= w_last_row ? '0 : (w_y + C_ONE);
      end else begin
        r_col <= w_x + C_ONE;
        r_row <= w_y;
      end
    end
  end

  // Line buffers, read-first: the old lb0 entry ages into lb1.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_lb1[w_addr] <= w_lb0_rd;
      r_lb0[w_addr] <= pix_in;
    end
  end

  // Column shift registers advance by one lane per accepted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_top <= '0;
      r_sh_mid <= '0;
      r_sh_bot <= '0;
    end else if (w_acc) begin
      r_sh_top <= w_top_nxt;
      r_sh_mid <= w_mid_nxt;
      r_sh_bot <= w_bot_nxt;
    end
  end

  // Output register: strobe on completed interior windows, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid <= 1'b0;
      win_top   <= '0;
      win_mid   <= '0;
      win_bot   <= '0;
      win_x     <= '0;
      win_y     <= '0;
    end else begin
      win_valid <= w_acc && w_win;
      if (w_acc && w_win) begin
        win_top <= w_top_nxt;
        win_mid <= w_mid_nxt;
        win_bot <= w_bot_nxt;
        win_x   <= w_x - C_ONE;
        win_y   <= w_y - C_ONE;
      end
    end
  end

`ifdef WINDOW_FRAME_CHK_EN
  logic r_seen_frame;
  logic w_at_origin;

  // Counters sitting at (0,0) mean the previous frame ended cleanly.
  always_comb begin
    w_at_origin = (r_col == '0) && (r_row == '0);
  end

  // Sticky frame error: sof arriving mid-frame, or an unmarked pixel at the
  // origin once at least one full frame has gone by.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seen_frame <= 1'b0;
      frame_err    <= 1'b0;
    end else if (w_acc) begin
      if (w_last_col && w_last_row) begin
        r_seen_frame <= 1'b1;
      end
      if ((sof && !w_at_origin) || (!sof && w_at_origin && r_seen_frame)) begin
        frame_err <= 1'b1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_window_3x3_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_window_3x3_gen
// Purpose  : Self-checking bench for window_3x3_gen on a 4x4 image.
//            Expected windows come from a full-frame image model and are
//            queued per accepted pixel with the cycle they are due.
// Revision : 1.0 - initial release
// ============================================================================
module tb_window_3x3_gen;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int AW = 10;

  typedef struct {
    logic [3*DW-1:0] top;
    logic [3*DW-1:0] mid;
    logic [3*DW-1:0] bot;
    logic [AW-1:0]   x;
    logic [AW-1:0]   y;
    int              due;
  } win_t;

  logic              clk;
  logic              rst_n;
  logic [DW-1:0]     pix_in;
  logic              pix_valid;
  logic              sof;
  logic [3*DW-1:0]   win_top;
  logic [3*DW-1:0]   win_mid;
  logic [3*DW-1:0]   win_bot;
  logic              win_valid;
  logic [AW-1:0]     win_x;
  logic [AW-1:0]     win_y;
`ifdef WINDOW_FRAME_CHK_EN
  logic              frame_err;
`endif

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   bx     = 0;
  int   by     = 0;
  logic [DW-1:0] img [0:H-1][0:W-1];
  win_t exp_q[$];
  win_t got_q[$];
  win_t m_e;
  win_t m_g;

  window_3x3_gen #(
    .DATA_W(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pix_in(pix_in),
    .pix_valid(pix_valid),
    .sof(sof),
    .win_top(win_top),
    .win_mid(win_mid),
    .win_bot(win_bot),
    .win_valid(win_valid),
    .win_x(win_x),
    .win_y(win_y)
`ifdef WINDOW_FRAME_CHK_EN
    ,
    .frame_err(frame_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every cycle either the head window is due and must
  // match, or win_valid must be low.
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        m_e = exp_q.pop_front();
        checks++;
        if (win_valid !== 1'b1) begin
          errors++;
          $display("FAIL win_valid_pulse got=%b exp=1 at x=%0d y=%0d", win_valid, m_e.x, m_e.y);
        end else begin
          m_g.top = win_top; m_g.mid = win_mid; m_g.bot = win_bot;
          m_g.x = win_x; m_g.y = win_y; m_g.due = cyc;
          got_q.push_back(m_g);
          checks++;
          if ({win_top, win_mid, win_bot, win_x, win_y} !== {m_e.top, m_e.mid, m_e.bot, m_e.x, m_e.y}) begin
            errors++;
            $display("FAIL window_data got=%h/%h/%h x=%0d y=%0d exp=%h/%h/%h x=%0d y=%0d",
                     win_top, win_mid, win_bot, win_x, win_y, m_e.top, m_e.mid, m_e.bot, m_e.x, m_e.y);
          end
        end
      end else begin
        checks++;
        if (win_valid !== 1'b0) begin
          errors++;
          $display("FAIL spurious_win_valid got=%b exp=0 cycle=%0d", win_valid, cyc);
        end
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pix_valid = 1'b0;
      sof       = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    sof       = 1'b0;
    exp_q.delete();
    bx = 0;
    by = 0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Drive one pixel after an optional idle gap; queue the window it completes.
  task automatic drive_pix(input logic [DW-1:0] v, input logic s, input int gap);
    win_t e;
    idle(gap);
    @(negedge clk);
    pix_valid = 1'b1;
    sof       = s;
    pix_in    = v;
    if (s) begin
      bx = 0;
      by = 0;
    end
    img[by][bx] = v;
    if (bx >= 2 && by >= 2) begin
      e.top = {img[by-2][bx], img[by-2][bx-1], img[by-2][bx-2]};
      e.mid = {img[by-1][bx], img[by-1][bx-1], img[by-1][bx-2]};
      e.bot = {img[by][bx],   img[by][bx-1],   img[by][bx-2]};
      e.x   = AW'(bx - 1);
      e.y   = AW'(by - 1);
      e.due = cyc + 1;
      exp_q.push_back(e);
    end
    if (bx == W - 1) begin
      bx = 0;
      by = (by == H - 1) ? 0 : by + 1;
    end else begin
      bx = bx + 1;
    end
  endtask

  // First npix pixels of a frame valued base + row*16 + col.
  task automatic drive_frame(input int base, input int max_gap, input logic sof_first, input int npix);
    for (int p = 0; p < npix; p++) begin
      drive_pix(DW'(base + (p / W) * 16 + (p % W)), sof_first && (p == 0),
                (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pix_valid = 1'b0; sof = 1'b0; pix_in = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (win_valid !== 1'b0) begin errors++; $display("FAIL reset_win_valid got=%b exp=0", win_valid); end
    checks++;
    if ({win_top, win_mid, win_bot} !== '0) begin
      errors++; $display("FAIL reset_buses got=%h/%h/%h exp=0", win_top, win_mid, win_bot);
    end
    checks++;
    if ({win_x, win_y} !== '0) begin errors++; $display("FAIL reset_coords got=%0d,%0d exp=0,0", win_x, win_y); end
`ifdef WINDOW_FRAME_CHK_EN
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
`endif
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_continuous();
    got_q.delete();
    drive_frame(0, 0, 1'b1, W * H);
    idle(3);
    checks++;
    if (got_q.size() != 4) begin errors++; $display("FAIL cont_count got=%0d exp=4", got_q.size()); end
    checks++;
    if ({got_q[0].top, got_q[0].mid, got_q[0].bot} !== 72'h020100_121110_222120) begin
      errors++; $display("FAIL cont_first got=%h/%h/%h exp=020100/121110/222120", got_q[0].top, got_q[0].mid, got_q[0].bot);
    end
    checks++;
    if (got_q[0].x !== 10'd1 || got_q[0].y !== 10'd1) begin
      errors++; $display("FAIL cont_first_xy got=%0d,%0d exp=1,1", got_q[0].x, got_q[0].y);
    end
    checks++;
    if (got_q[3].x !== 10'd2 || got_q[3].y !== 10'd2 || got_q[3].bot[3*DW-1:2*DW] !== 8'h33) begin
      errors++; $display("FAIL cont_last got=%0d,%0d pix=%h exp=2,2 pix=33", got_q[3].x, got_q[3].y, got_q[3].bot[3*DW-1:2*DW]);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL cont_pending got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_gaps();
    got_q.delete();
    drive_frame(0, 5, 1'b1, W * H);
    idle(3);
    checks++;
    if (got_q.size() != 4) begin errors++; $display("FAIL gaps_count got=%0d exp=4", got_q.size()); end
    checks++;
    if ({got_q[0].top, got_q[0].mid, got_q[0].bot} !== 72'h020100_121110_222120) begin
      errors++; $display("FAIL gaps_first got=%h/%h/%h exp=020100/121110/222120", got_q[0].top, got_q[0].mid, got_q[0].bot);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL gaps_pending got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    got_q.delete();
    drive_frame(0, 0, 1'b1, W * H);
    drive_frame(8'h80, 0, 1'b1, W * H);
    idle(3);
    checks++;
    if (got_q.size() != 8) begin errors++; $display("FAIL b2b_count got=%0d exp=8", got_q.size()); end
    for (int i = 4; i < 8; i++) begin
      checks++;
      if (got_q[i].top[7] !== 1'b1 || got_q[i].top[15] !== 1'b1 || got_q[i].top[23] !== 1'b1 ||
          got_q[i].mid[7] !== 1'b1 || got_q[i].mid[15] !== 1'b1 || got_q[i].mid[23] !== 1'b1 ||
          got_q[i].bot[7] !== 1'b1 || got_q[i].bot[15] !== 1'b1 || got_q[i].bot[23] !== 1'b1) begin
        errors++; $display("FAIL b2b_stale win%0d got=%h/%h/%h exp=all bytes >= 80", i, got_q[i].top, got_q[i].mid, got_q[i].bot);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    got_q.delete();
    drive_frame(0, 0, 1'b1, 10);
    do_reset();
    drive_frame(8'h40, 0, 1'b1, W * H);
    idle(3);
    checks++;
    if (got_q.size() != 4) begin errors++; $display("FAIL rstmid_count got=%0d exp=4", got_q.size()); end
    checks++;
    if (got_q[0].bot !== 24'h626160 || got_q[0].top !== 24'h424140) begin
      errors++; $display("FAIL rstmid_first got=%h/%h exp=424140/626160", got_q[0].top, got_q[0].bot);
    end
  endtask

  task automatic test_sof_mid_frame();
    got_q.delete();
    drive_frame(0, 0, 1'b1, 6);
    drive_frame(8'h40, 0, 1'b1, W * H);
    idle(3);
    checks++;
    if (got_q.size() != 4) begin errors++; $display("FAIL sofmid_count got=%0d exp=4", got_q.size()); end
    checks++;
    if (got_q[0].x !== 10'd1 || got_q[0].y !== 10'd1 || got_q[3].x !== 10'd2 || got_q[3].y !== 10'd2) begin
      errors++; $display("FAIL sofmid_xy got=%0d,%0d..%0d,%0d exp=1,1..2,2", got_q[0].x, got_q[0].y, got_q[3].x, got_q[3].y);
    end
    checks++;
    if (got_q[0].mid !== 24'h525150) begin errors++; $display("FAIL sofmid_mid got=%h exp=525150", got_q[0].mid); end
  endtask

`ifdef WINDOW_FRAME_CHK_EN
  task automatic test_frame_err();
    do_reset();
    drive_frame(0, 0, 1'b1, 6);
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_before got=%b exp=0", frame_err); end
    drive_frame(8'h40, 0, 1'b1, 1);
    idle(1);
    checks++;
    if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_set got=%b exp=1", frame_err); end
    idle(4);
    checks++;
    if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_sticky got=%b exp=1", frame_err); end
    do_reset();
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_cleared got=%b exp=0", frame_err); end
    drive_frame(0, 0, 1'b1, W * H);
    drive_frame(8'h80, 0, 1'b1, W * H);
    idle(3);
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clean got=%b exp=0", frame_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_continuous();
    test_gaps();
    test_back_to_back();
    test_reset_mid_frame();
    test_sof_mid_frame();
`ifdef WINDOW_FRAME_CHK_EN
    test_frame_err();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
